// File: rtl/dm_load_unit_pkg.sv
// rtl/dm_load_unit_pkg.sv - shared DMop, state, error encodings and lane-enable helper
package dm_load_unit_pkg;

   typedef logic [1:0] dm_op_t;
   typedef logic [1:0] dm_err_t;

   // DMop encodings, identical to the store path
   localparam dm_op_t DM_BYTE = 2'b00;
   localparam dm_op_t DM_HALF = 2'b01;
   localparam dm_op_t DM_ILL  = 2'b10;
   localparam dm_op_t DM_WORD = 2'b11;

   // Load FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_REQ  = 2'b01;
   localparam logic [1:0] ST_WAIT = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   // Error codes reported with ld_done
   localparam dm_err_t ERR_NONE     = 2'b00;
   localparam dm_err_t ERR_MISALIGN = 2'b01;
   localparam dm_err_t ERR_ILLOP    = 2'b10;
   localparam dm_err_t ERR_TIMEOUT  = 2'b11;

   // Byte-lane enables for an access; lane0 = bits[7:0]. Shared with the store side.
   function automatic logic [3:0] dm_lane_be(input dm_op_t op, input logic [1:0] addr);
      logic [3:0] be;
      case (op)
         DM_WORD: be = 4'b1111;
         DM_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
         DM_BYTE: be = 4'b0001 << addr;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Halfwords need addr[0]=0, words need addr=00
   function automatic logic dm_misaligned(input dm_op_t op, input logic [1:0] addr);
      return ((op == DM_HALF) && addr[0]) || ((op == DM_WORD) && (addr != 2'b00));
   endfunction

endpackage

// File: rtl/dm_lane_extract.sv
// rtl/dm_lane_extract.sv - selects the addressed byte/halfword and sign/zero-extends it
module dm_lane_extract
   import dm_load_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  dm_op_t      op,
   input  logic        uns,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the lane and extend; unsigned loads fill with zeros, signed with the field MSB
   always_comb begin
      byte_v = rdata[{addr, 3'b000} +: 8];
      half_v = addr[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         DM_BYTE: result = {{24{~uns & byte_v[7]}}, byte_v};
         DM_HALF: result = {{16{~uns & half_v[15]}}, half_v};
         DM_WORD: result = rdata;
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - load FSM: one memory read, lane extract, MDR capture, error report
module dm_load_unit
   import dm_load_unit_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int DW      = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_start,
   input  logic [1:0]    ld_addr,
   input  logic [1:0]    ld_op,
   input  logic          ld_unsigned,
   output logic          mem_req,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rvalid,
   output logic [DW-1:0] mdr_out,
   output logic          ld_done,
   output logic          ld_err,
   output logic [1:0]    ld_err_code,
   output logic          busy
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   generate
      if (DW != 32) begin : g_dw_check
         $error("dm_load_unit supports only DW=32");
      end
      if (TIMEOUT < 1) begin : g_to_check
         $error("dm_load_unit requires TIMEOUT >= 1");
      end
   endgenerate

   logic [1:0]    state;
   logic [1:0]    addr_q;
   dm_op_t        op_q;
   logic          uns_q;
   dm_err_t       err_q;
   logic [CW-1:0] cnt;
   logic [DW-1:0] mdr_q;
   logic [31:0]   ext;

   dm_lane_extract u_extract (
      .rdata  (mem_rdata),
      .addr   (addr_q),
      .op     (op_q),
      .uns    (uns_q),
      .result (ext)
   );

   // Command sequencing, timeout counting and MDR capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         addr_q <= 2'b00;
         op_q   <= DM_BYTE;
         uns_q  <= 1'b0;
         err_q  <= ERR_NONE;
         cnt    <= '0;
         mdr_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ld_start) begin
                  addr_q <= ld_addr;
                  op_q   <= ld_op;
                  uns_q  <= ld_unsigned;
                  if (ld_op == DM_ILL) begin
                     err_q <= ERR_ILLOP;
                     state <= ST_DONE;
                  end else if (dm_misaligned(ld_op, ld_addr)) begin
                     err_q <= ERR_MISALIGN;
                     state <= ST_DONE;
                  end else begin
                     err_q <= ERR_NONE;
                     state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  mdr_q <= ext;
                  err_q <= ERR_NONE;
                  state <= ST_DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err_q <= ERR_TIMEOUT;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode straight from the state register so reset clears them at once
   always_comb begin
      mem_req     = (state == ST_REQ);
      mem_be      = ((state == ST_REQ) || (state == ST_WAIT)) ? dm_lane_be(op_q, addr_q) : 4'b0000;
      ld_done     = (state == ST_DONE);
      ld_err      = (state == ST_DONE) && (err_q != ERR_NONE);
      ld_err_code = (state == ST_DONE) ? err_q : ERR_NONE;
      busy        = (state != ST_IDLE);
      mdr_out     = mdr_q;
   end

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - scoreboard bench for dm_load_unit
module tb_dm_load_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_start = 1'b0;
   logic [1:0]  ld_addr = 2'b00;
   logic [1:0]  ld_op = 2'b00;
   logic        ld_unsigned = 1'b0;
   logic        mem_req;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mdr_out;
   logic        ld_done;
   logic        ld_err;
   logic [1:0]  ld_err_code;
   logic        busy;

   dm_load_unit #(.TIMEOUT(TO), .DW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_start    (ld_start),
      .ld_addr     (ld_addr),
      .ld_op       (ld_op),
      .ld_unsigned (ld_unsigned),
      .mem_req     (mem_req),
      .mem_be      (mem_be),
      .mem_rdata   (mem_rdata),
      .mem_rvalid  (mem_rvalid),
      .mdr_out     (mdr_out),
      .ld_done     (ld_done),
      .ld_err      (ld_err),
      .ld_err_code (ld_err_code),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mdr;
      logic        err;
      logic [1:0]  code;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  be_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] model_mdr = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: pops expectations whenever the DUT requests memory or completes a load
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) begin
            if (be_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_mem_req: got be %b expected no request", mem_be);
            end else begin
               logic [3:0] eb;
               eb = be_q.pop_front();
               chk("mem_be", {28'h0, mem_be}, {28'h0, eb});
            end
         end
         if (ld_done) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_done: got code %b expected no completion", ld_err_code);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("mdr_out", mdr_out, e.mdr);
               chk("ld_err", {31'h0, ld_err}, {31'h0, e.err});
               chk("ld_err_code", {30'h0, ld_err_code}, {30'h0, e.code});
            end
         end
      end
   end

   // Issue one load; d = WAIT cycle carrying rvalid (0 = none), lat = expected ld_done cycle
   task automatic do_load(input logic [1:0] a, input logic [1:0] op, input logic u,
                          input logic [31:0] rd, input int d, input logic [31:0] exp_mdr,
                          input logic [1:0] code, input logic [3:0] be, input int lat,
                          input bit stray);
      exp_t e;
      int   cyc;
      int   done_cyc;
      e.mdr  = (code == 2'b00) ? exp_mdr : model_mdr;
      e.err  = (code != 2'b00);
      e.code = code;
      exp_q.push_back(e);
      if (code == 2'b00 || code == 2'b11) be_q.push_back(be);
      if (code == 2'b00) model_mdr = exp_mdr;
      @(posedge clk); #1;
      ld_start = 1'b1; ld_addr = a; ld_op = op; ld_unsigned = u; mem_rdata = rd;
      cyc = 0;
      done_cyc = -1;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) ld_start = 1'b0;
         if (stray && cyc == 3) begin ld_start = 1'b1; ld_op = 2'b10; end
         if (stray && cyc == 4) ld_start = 1'b0;
         if (ld_done) begin done_cyc = cyc; break; end
         mem_rvalid = (d != 0) && (cyc == 1 + d);
      end
      mem_rvalid = 1'b0;
      ld_start = 1'b0;
      chk("done_latency", done_cyc, lat);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mdr", mdr_out, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_be", {28'h0, mem_be}, 32'h0);
      chk("rst_done", {31'h0, ld_done}, 32'h0);
      chk("rst_err", {29'h0, ld_err, ld_err_code}, 32'h0);
      rst = 1'b0;

      // Successful loads: addr, op, unsigned, rdata, rvalid WAIT cycle, mdr, code, be, latency
      do_load(2'b00, 2'b11, 1'b0, 32'h12345678, 1, 32'h12345678, 2'b00, 4'b1111, 3, 1'b0);
      do_load(2'b11, 2'b00, 1'b0, 32'h80AABBCC, 1, 32'hFFFFFF80, 2'b00, 4'b1000, 3, 1'b0);
      do_load(2'b11, 2'b00, 1'b1, 32'h80AABBCC, 1, 32'h00000080, 2'b00, 4'b1000, 3, 1'b0);
      do_load(2'b01, 2'b00, 1'b0, 32'h80AABBCC, 2, 32'hFFFFFFBB, 2'b00, 4'b0010, 4, 1'b0);
      do_load(2'b00, 2'b00, 1'b1, 32'h80AABBCC, 1, 32'h000000CC, 2'b00, 4'b0001, 3, 1'b0);
      do_load(2'b10, 2'b00, 1'b0, 32'h80AABBCC, 1, 32'hFFFFFFAA, 2'b00, 4'b0100, 3, 1'b0);
      do_load(2'b10, 2'b01, 1'b1, 32'hBEEF1234, 1, 32'h0000BEEF, 2'b00, 4'b1100, 3, 1'b0);
      do_load(2'b10, 2'b01, 1'b0, 32'hBEEF1234, 1, 32'hFFFFBEEF, 2'b00, 4'b1100, 3, 1'b0);
      do_load(2'b00, 2'b01, 1'b0, 32'hBEEF1234, 1, 32'h00001234, 2'b00, 4'b0011, 3, 1'b0);

      // Errors without memory access
      do_load(2'b01, 2'b01, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 2'b01, 4'b0000, 1, 1'b0);
      do_load(2'b00, 2'b10, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 2'b10, 4'b0000, 1, 1'b0);
      do_load(2'b10, 2'b11, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 2'b01, 4'b0000, 1, 1'b0);

      // ld_start during WAIT is ignored
      do_load(2'b00, 2'b11, 1'b0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 2'b00, 4'b1111, 5, 1'b1);

      // Timeout, then rvalid on the last allowed WAIT cycle
      do_load(2'b00, 2'b11, 1'b0, 32'h11111111, 0, 32'h0, 2'b11, 4'b1111, 2 + TO, 1'b0);
      do_load(2'b00, 2'b11, 1'b0, 32'h55AA55AA, TO, 32'h55AA55AA, 2'b00, 4'b1111, 2 + TO, 1'b0);

      // Stray rvalid in IDLE
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("stray_rvalid_mdr", mdr_out, model_mdr);
      chk("stray_rvalid_busy", {31'h0, busy}, 32'h0);

      // Reset asserted in WAIT aborts the load
      be_q.push_back(4'b1111);
      @(posedge clk); #1;
      ld_start = 1'b1; ld_addr = 2'b00; ld_op = 2'b11; ld_unsigned = 1'b0;
      @(posedge clk); #1;
      ld_start = 1'b0;
      @(posedge clk); #1;
      chk("wait_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      chk("abort_mdr", mdr_out, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_be", {28'h0, mem_be}, 32'h0);
      chk("abort_done", {31'h0, ld_done}, 32'h0);
      model_mdr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Normal load after reset release
      do_load(2'b01, 2'b00, 1'b1, 32'h0000F700, 1, 32'h000000F7, 2'b00, 4'b0010, 3, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_empty", exp_q.size(), 0);
      chk("be_q_empty", be_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
Load-side counterpart of the store byte-enable logic in the multicycle MIPS datapath. It accepts a load command (address low bits, DMop size, signedness) from the control FSM and issues one read to data memory, using the same byte-enable lane encoding as stores. When the word returns, it extracts the addressed byte or halfword, sign- or zero-extends it, and registers it into the MDR. It also reports misalignment, illegal op and memory timeout as errors.

Parameters:
TIMEOUT, 16, maximum WAIT cycles without mem_rvalid before a timeout error (>=1)
DW, 32, data word width (fixed 32 in this design; asserted at elaboration)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ld_start  input  1  load command strobe, accepted only in IDLE
ld_addr  input  2  address bits [1:0] of the load
ld_op  input  2  DMop: 00 byte, 01 halfword, 11 word, 10 illegal
ld_unsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
mem_req  output  1  one-cycle read request to data memory
mem_be  output  4  read byte lanes; lane0 = bits[7:0]
mem_rdata  input  32  memory read word
mem_rvalid  input  1  mem_rdata valid this cycle
mdr_out  output  32  registered, extended load result
ld_done  output  1  one-cycle completion pulse
ld_err  output  1  valid with ld_done; 1 = load failed
ld_err_code  output  2  00 none, 01 misaligned, 10 illegal op, 11 timeout
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; mdr_out=0, mem_req=0, mem_be=0, ld_done=0, ld_err=0, ld_err_code=00, busy=0; timeout counter=0. Reset asserted mid-operation aborts the load. No done pulse is produced and mdr_out clears.
- IDLE: on ld_start, latch addr/op/unsigned.
  - op=10 -> DONE with code 10.
  - Half with addr[0]=1, or word with addr!=00 -> DONE with code 01.
  - Error paths issue no mem_req.
  - Otherwise -> REQ.
- REQ: mem_req=1 for exactly this cycle. mem_be is driven from REQ through WAIT and is 0 elsewhere:
  - word: 1111
  - half: addr[1]=0 -> 0011, addr[1]=1 -> 1100
  - byte: 0001, 0010, 0100, 1000 for addr 00, 01, 10, 11
  - Clear counter; next state WAIT.
- WAIT: mem_rvalid is sampled only here.
  - On rvalid: mdr_out <= extended lane; -> DONE, no error.
  - Otherwise counter++. When counter==TIMEOUT-1 and no rvalid -> DONE with code 11. rvalid is therefore accepted on WAIT cycles 1..TIMEOUT.
- Extension:
  - byte = rdata[8*addr+7 : 8*addr]
  - half = rdata[16*addr[1]+15 : 16*addr[1]]
  - Upper bits = 0 if ld_unsigned, else the replicated MSB of the extracted field. Word loads pass through unchanged.
- DONE: ld_done=1 for one cycle; ld_err/ld_err_code are valid this cycle only and 0 otherwise. Then -> IDLE.
- mdr_out is updated only on a successful WAIT capture. It holds across errors and idle cycles.
- Ignored inputs: ld_start outside IDLE; mem_rvalid outside WAIT (stray).
- Latency:
  - Success: ld_start cycle 0, REQ cycle 1, rvalid earliest cycle 2, ld_done cycle 3 (rvalid cycle + 1).
  - Error without memory access: ld_done in cycle 1.
  - Back-to-back: the next ld_start is accepted in the cycle after DONE.

Decomposition:
- Shared package: DMop encodings (DM_BYTE=00, DM_HALF=01, DM_ILL=10, DM_WORD=11), state encoding (IDLE, REQ, WAIT, DONE), error codes, and a lane-enable function shared with the store byte-enable logic so both ends use one encoding.
- One combinational sub-module, dm_lane_extract (rdata, addr, op, unsigned -> 32-bit result). The FSM, counter and MDR stay in the top.

Test Plan:
- Word: start addr=00 op=11, rvalid cycle 2 with rdata=0x12345678 -> mem_be=1111 in REQ, ld_done cycle 3, mdr_out=0x12345678, ld_err=0.
- Signed byte: addr=11 op=00 unsigned=0, rdata=0x80AABBCC -> mem_be=1000, mdr_out=0xFFFFFF80. Repeat with unsigned=1 -> 0x00000080.
- Halfword: addr=10 op=01 unsigned=1, rdata=0xBEEF1234 -> mem_be=1100, mdr_out=0x0000BEEF. Signed with addr=00 -> 0x00001234.
- Errors: half at addr=01 -> no mem_req, ld_done cycle 1, code 01, mdr_out unchanged. op=10 -> code 10. ld_start during WAIT is ignored.
- Timeout: TIMEOUT=4, no rvalid -> ld_done with code 11 one cycle after 4th WAIT cycle. With rvalid on 4th WAIT cycle -> success. Stray rvalid in IDLE leaves mdr_out unchanged.
- Reset: assert rst in WAIT -> all outputs 0 immediately, no ld_done. After release, a new load completes normally.
